// File: rtl/reg_file_pkg.sv
// Shared constants, FSM encoding and bus-slicing helper for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_NUM_READ   = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Lowest bit index of port k in a flattened bus of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation, cleared by a write.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEF_NUM_READ
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_en,
    input  logic [ADDR_WIDTH-1:0]          set_addr,
    input  logic                           clr_en,
    input  logic [ADDR_WIDTH-1:0]          clr_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ-1:0]            pend_raw
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next pending vector; a reservation overrides a same-address write.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) begin
            pend_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pend_d[set_addr] = 1'b1;
        end
    end

    // Pending bits with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
        assign pend_raw[k] = pend_q[rd_addr[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass, optional x0, pending scoreboard and post-reset clear engine.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEF_NUM_READ,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           WRITE,
    input  logic [ADDR_WIDTH-1:0]          INADDRESS,
    input  logic [DATA_WIDTH-1:0]          IN,
    input  logic                           RSV_EN,
    input  logic [ADDR_WIDTH-1:0]          RSV_ADDR,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
    output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
    output logic [NUM_READ-1:0]            PEND,
    output logic                           BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic                    busy;
    logic                    idle_ok;
    logic                    wr_en;
    logic                    rsv_en;
    logic [NUM_READ-1:0]     pend_raw;

    assign busy    = (state_q == ST_CLEAR);
    assign BUSY    = busy;
    // Accesses are only honoured in IDLE and never in a reset cycle.
    assign idle_ok = (state_q == ST_IDLE) && !RESET;
    assign wr_en   = idle_ok && WRITE  && !(ZERO_REG && (INADDRESS == '0));
    assign rsv_en  = idle_ok && RSV_EN && !(ZERO_REG && (RSV_ADDR == '0));

    // Clear-engine sequencing: walk the counter through every entry, then go idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM and counter registers with synchronous reset that restarts the clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next array contents: clear one entry per cycle while busy, else apply the WB write.
    always_comb begin
        mem_d = mem_q;
        if (busy && !RESET) begin
            mem_d[cnt_q] = '0;
        end else if (wr_en) begin
            mem_d[INADDRESS] = IN;
        end
    end

    // Storage array; contents are initialised by the clear engine, not by reset.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    reg_file_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ)
    ) u_scoreboard (
        .clk      (CLK),
        .rst      (RESET),
        .set_en   (rsv_en),
        .set_addr (RSV_ADDR),
        .clr_en   (wr_en),
        .clr_addr (INADDRESS),
        .rd_addr  (OUTADDRESS),
        .pend_raw (pend_raw)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  is_zero;
        logic                  hit;

        assign a       = OUTADDRESS[slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
        assign is_zero = ZERO_REG && (a == '0);
        assign hit     = BYPASS && wr_en && (INADDRESS == a);

        assign OUT[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] =
            (busy || is_zero) ? '0 :
            hit               ? IN : mem_q[a];

        assign PEND[k] = !busy && !is_zero && pend_raw[k] && !hit;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default instance plus a no-bypass instance).
module tb_reg_file_mp;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WRITE;
    logic [4:0]  INADDRESS;
    logic [31:0] IN;
    logic        RSV_EN;
    logic [4:0]  RSV_ADDR;
    logic [9:0]  OUTADDRESS;
    logic [63:0] out_a, out_b;
    logic [1:0]  pend_a, pend_b;
    logic        busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    reg_file_mp dut (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .OUTADDRESS(OUTADDRESS),
        .OUT(out_a), .PEND(pend_a), .BUSY(busy_a)
    );

    reg_file_mp #(.BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR), .OUTADDRESS(OUTADDRESS),
        .OUT(out_b), .PEND(pend_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
        OUTADDRESS = {a1, a0};
    endtask

    task automatic idle_in();
        WRITE  = 1'b0;
        RSV_EN = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; WRITE = 1'b0; INADDRESS = '0; IN = '0;
        RSV_EN = 1'b0; RSV_ADDR = '0; OUTADDRESS = '0;

        // Reset held for two edges
        step();
        chk("busy_in_reset", 64'(busy_a), 64'd1);
        chk("out_in_reset", out_a, 64'd0);
        step();
        RESET = 1'b0;

        // Exactly 32 busy cycles; a write and reserve of r3 mid-clear are dropped
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin
                WRITE = 1'b1; INADDRESS = 5'd3; IN = 32'h0000DEAD;
                RSV_EN = 1'b1; RSV_ADDR = 5'd3; setrd(5'd3, 5'd3);
            end
            #1;
            chk($sformatf("busy_clear_%0d", i), 64'(busy_a), 64'd1);
            if (i == 5) begin
                chk("out_during_busy", out_a, 64'd0);
                chk("pend_during_busy", 64'(pend_a), 64'd0);
            end
            step();
            idle_in();
        end
        #1;
        chk("busy_done", 64'(busy_a), 64'd0);
        chk("busy_done_nb", 64'(busy_b), 64'd0);

        // Every entry reads zero after the clear
        for (int a = 0; a < 32; a++) begin
            setrd(5'(a), 5'(31 - a));
            #1;
            chk($sformatf("cleared_r%0d", a), out_a, 64'd0);
        end
        setrd(5'd3, 5'd3);
        #1;
        chk("r3_pend_dropped", 64'(pend_a), 64'd0);

        // Write r5 and r10 on consecutive edges, then read both
        WRITE = 1'b1; INADDRESS = 5'd5; IN = 32'h1;
        step();
        INADDRESS = 5'd10; IN = 32'h2;
        step();
        idle_in();
        setrd(5'd5, 5'd10);
        #1;
        chk("rd_r5_r10", out_a, {32'h2, 32'h1});
        chk("rd_pend", 64'(pend_a), 64'd0);

        // Same-cycle write of r7 with a read of r7
        WRITE = 1'b1; INADDRESS = 5'd7; IN = 32'hCAFEBABE;
        setrd(5'd7, 5'd5);
        #1;
        chk("bypass_on", out_a, {32'h1, 32'hCAFEBABE});
        chk("bypass_off_old", out_b, {32'h1, 32'h0});
        step();
        idle_in();
        #1;
        chk("bypass_off_next", out_b[31:0], 64'hCAFEBABE);
        chk("bypass_on_next", out_a[31:0], 64'hCAFEBABE);

        // x0: write and reserve both ignored
        WRITE = 1'b1; INADDRESS = 5'd0; IN = 32'hFFFFFFFF;
        RSV_EN = 1'b1; RSV_ADDR = 5'd0;
        setrd(5'd0, 5'd0);
        #1;
        chk("x0_same_cycle", out_a, 64'd0);
        chk("x0_pend_same", 64'(pend_a), 64'd0);
        step();
        idle_in();
        #1;
        chk("x0_after", out_a, 64'd0);
        chk("x0_after_nb", out_b, 64'd0);
        chk("x0_pend_after", 64'(pend_a), 64'd0);

        // Reserve r12 at t, visible from t+1, cleared by a write at t+4
        RSV_EN = 1'b1; RSV_ADDR = 5'd12;
        setrd(5'd12, 5'd12);
        #1;
        chk("rsv_not_same_cycle", 64'(pend_a), 64'd0);
        step();
        idle_in();
        #1;
        chk("rsv_t1", 64'(pend_a), 64'b11);
        step();
        step();
        #1;
        chk("rsv_t3", 64'(pend_a), 64'b11);
        step();
        WRITE = 1'b1; INADDRESS = 5'd12; IN = 32'h55;
        #1;
        chk("wb_t4_out", out_a[31:0], 64'h55);
        chk("wb_t4_pend", 64'(pend_a), 64'd0);
        chk("wb_t4_pend_nb", 64'(pend_b), 64'b11);
        chk("wb_t4_out_nb", out_b[31:0], 64'h0);
        step();
        idle_in();
        #1;
        chk("wb_after_pend", 64'(pend_a), 64'd0);
        chk("wb_after_out", out_a, {32'h55, 32'h55});

        // Reserve and write of r12 in the same cycle: reserve wins
        WRITE = 1'b1; INADDRESS = 5'd12; IN = 32'h66;
        RSV_EN = 1'b1; RSV_ADDR = 5'd12;
        #1;
        chk("rsvwr_same_out", out_a[31:0], 64'h66);
        chk("rsvwr_same_pend", 64'(pend_a), 64'd0);
        step();
        idle_in();
        #1;
        chk("rsvwr_pend", 64'(pend_a), 64'b11);
        chk("rsvwr_out", out_a[31:0], 64'h66);

        // Reset, then a second reset pulse 10 cycles into the clear
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("busy_pre_%0d", i), 64'(busy_a), 64'd1);
            step();
        end
        RESET = 1'b1;
        #1;
        chk("busy_in_pulse", 64'(busy_a), 64'd1);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk($sformatf("busy_re_%0d", i), 64'(busy_a), 64'd1);
            step();
        end
        #1;
        chk("busy_re_done", 64'(busy_a), 64'd0);
        setrd(5'd12, 5'd5);
        #1;
        chk("re_pend_clear", 64'(pend_a), 64'd0);
        chk("re_out_clear", out_a, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
